// File: rtl/mod_reduce_pipe_if.sv
// mod_reduce_pipe_if: modulus-load and x/result handshake bundle; out_quot exists only with MOD_REDUCE_QUOT_EN
interface mod_reduce_pipe_if #(
  parameter int IN_W = 300,
  parameter int MOD_W = 256
);
  localparam int N = IN_W - MOD_W + 1;
  logic mod_load, mod_ack, mod_err, mod_valid;
  logic [MOD_W-1:0] mod_in;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [IN_W-1:0] x;
  logic [MOD_W-1:0] out_rem;
`ifdef MOD_REDUCE_QUOT_EN
  logic [N-1:0] out_quot;
  modport master (
    output mod_load, mod_in, in_valid, x, out_ready,
    input mod_ack, mod_err, mod_valid, in_ready, out_valid, out_rem, out_quot
  );
  modport slave (
    input mod_load, mod_in, in_valid, x, out_ready,
    output mod_ack, mod_err, mod_valid, in_ready, out_valid, out_rem, out_quot
  );
`else
  modport master (
    output mod_load, mod_in, in_valid, x, out_ready,
    input mod_ack, mod_err, mod_valid, in_ready, out_valid, out_rem
  );
  modport slave (
    input mod_load, mod_in, in_valid, x, out_ready,
    output mod_ack, mod_err, mod_valid, in_ready, out_valid, out_rem
  );
`endif
endinterface

// File: rtl/mod_reduce_pipe.sv
// mod_reduce_pipe: pipelined x mod m with loadable m, one restoring stage per quotient bit; MOD_REDUCE_QUOT_EN adds out_quot
module mod_reduce_pipe #(
  parameter int IN_W = 300,
  parameter int MOD_W = 256
) (
  input logic clk,
  input logic reset,
  mod_reduce_pipe_if.slave bus
);
  localparam int N = IN_W - MOD_W + 1;
  logic [MOD_W-1:0] m;
  logic [N-1:0] v;
  logic adv, take, done;
  assign adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv && bus.mod_valid && !bus.mod_load;
  assign take = bus.in_valid && bus.in_ready;
  // a load completes only once every stage and the output register are empty
  assign done = bus.mod_load && !bus.mod_ack && !(|{bus.out_valid, v});
  always_ff @(posedge clk) begin
    if (reset) begin
      m <= '0;
      bus.mod_valid <= 1'b0;
      bus.mod_err <= 1'b0;
      bus.mod_ack <= 1'b0;
    end else begin
      bus.mod_ack <= done;
      if (done && bus.mod_in[MOD_W-1]) begin
        m <= bus.mod_in;
        bus.mod_valid <= 1'b1;
        bus.mod_err <= 1'b0;
      end else if (done) begin
        bus.mod_err <= 1'b1;
      end
    end
  end
  for (genvar k = 0; k < N; k++) begin : st
    localparam int S = N - 1 - k;
    localparam int RW = MOD_W + S;
    logic vr, vi, ge;
    logic [RW-1:0] r;
    logic [RW:0] ri, ms;
    if (k == 0) begin : g_in
      assign vi = take;
      assign ri = (RW+1)'(bus.x);
    end else begin : g_in
      assign vi = st[k-1].vr;
      assign ri = st[k-1].r;
    end
    assign ms = (RW+1)'(m) << S;
    assign ge = ri >= ms;
    assign v[k] = vr;
    always_ff @(posedge clk) begin
      if (reset) begin
        vr <= 1'b0;
        r <= '0;
      end else if (adv) begin
        vr <= vi;
        r <= RW'(ge ? ri - ms : ri);
      end
    end
`ifdef MOD_REDUCE_QUOT_EN
    logic [N-1:0] q, qi;
    if (k == 0) begin : g_q
      assign qi = '0;
    end else begin : g_q
      assign qi = st[k-1].q;
    end
    always_ff @(posedge clk) begin
      if (reset) q <= '0;
      else if (adv) q <= qi | (N'(ge) << S);
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_rem <= '0;
`ifdef MOD_REDUCE_QUOT_EN
      bus.out_quot <= '0;
`endif
    end else if (adv) begin
      bus.out_valid <= st[N-1].vr;
      bus.out_rem <= st[N-1].r;
`ifdef MOD_REDUCE_QUOT_EN
      bus.out_quot <= st[N-1].q;
`endif
    end
  end
endmodule

// File: tb/tb_mod_reduce_pipe.sv
// tb_mod_reduce_pipe: directed checks of mod_reduce_pipe at IN_W=8, MOD_W=4
module tb_mod_reduce_pipe;
  localparam int IN_W = 8, MOD_W = 4, N = 5;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  mod_reduce_pipe_if #(.IN_W(IN_W), .MOD_W(MOD_W)) bus();
  mod_reduce_pipe #(.IN_W(IN_W), .MOD_W(MOD_W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  int n_chk = 0, n_err = 0, n_out = 0, mm = 13, stalls = 0, x0, m0, c, base;
  int qx[$], qm[$];
  logic held_v = 1'b0;
  logic [MOD_W-1:0] held_rem;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      qx.delete();
      qm.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) chk("hold_rem", bus.out_rem, held_rem);
      held_v = bus.out_valid && !bus.out_ready;
      held_rem = bus.out_rem;
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        chk("out_has_expect", qx.size() > 0, 1);
        if (qx.size() > 0) begin
          x0 = qx.pop_front();
          m0 = qm.pop_front();
          chk("rem", bus.out_rem, x0 % m0);
`ifdef MOD_REDUCE_QUOT_EN
          chk("quot", bus.out_quot, x0 / m0);
`endif
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        qx.push_back(int'(bus.x));
        qm.push_back(mm);
      end
    end
  end

  task automatic send(input int xv);
    int n = 0;
    logic ok;
    bus.x = IN_W'(xv);
    bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 100);
    stalls += n - 1;
    bus.in_valid = 1'b0;
    chk("send_accept", ok, 1);
  endtask

  task automatic one(input int xv, input int r, input int q);
    int lat = 0;
    send(xv);
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, N);
    chk("rem_direct", bus.out_rem, r);
`ifdef MOD_REDUCE_QUOT_EN
    chk("quot_direct", bus.out_quot, q);
`else
    if (q < 0) $display("negative quotient");
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int v, output int cyc);
    bus.mod_in = MOD_W'(v);
    bus.mod_load = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus.mod_ack && cyc < 200);
    bus.mod_load = 1'b0;
    #1;
    chk("ack_seen", bus.mod_ack, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((qx.size() != 0 || bus.out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", n < 100, 1);
  endtask

  initial begin
    bus.mod_load = 1'b0;
    bus.mod_in = '0;
    bus.in_valid = 1'b0;
    bus.x = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_mod_valid", bus.mod_valid, 0);
    chk("rst_mod_err", bus.mod_err, 0);
    chk("rst_mod_ack", bus.mod_ack, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_rem", bus.out_rem, 0);
`ifdef MOD_REDUCE_QUOT_EN
    chk("rst_out_quot", bus.out_quot, 0);
`endif
    reset = 1'b0;
    load(13, c);
    chk("load_cycles", c, 1);
    chk("load_mod_valid", bus.mod_valid, 1);
    chk("load_mod_err", bus.mod_err, 0);
    chk("load_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    chk("ack_pulse", bus.mod_ack, 0);
    one(200, 5, 15);
    one(255, 8, 19);
    one(12, 12, 0);
    base = n_out;
    stalls = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 100) begin
        bus.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
      send(i);
    end
    drain();
    chk("stream_stalls", stalls, 0);
    chk("stream_count", n_out - base, 256);
    load(6, c);
    chk("bad_mod_err", bus.mod_err, 1);
    chk("bad_mod_valid", bus.mod_valid, 1);
    one(100, 9, 7);
    send(50);
    send(60);
    send(70);
    base = n_out;
    bus.mod_in = 4'd15;
    bus.mod_load = 1'b1;
    #1;
    chk("load_blocks_ready", bus.in_ready, 0);
    load(15, c);
    chk("drained_before_ack", n_out - base, 3);
    chk("good_mod_err", bus.mod_err, 0);
    mm = 15;
    one(100, 10, 6);
    for (int i = 0; i < 4; i++) send(10 * i + 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_mod_valid", bus.mod_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    reset = 1'b0;
    base = n_out;
    bus.in_valid = 1'b1;
    bus.x = 8'd77;
    repeat (12) @(posedge clk);
    #1;
    chk("postrst_in_ready", bus.in_ready, 0);
    chk("postrst_no_stale", n_out - base, 0);
    bus.in_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mod_reduce_pipe.md
Name: mod_reduce_pipe

Overview:
- Parametrised pipelined modular reducer: out_rem = x mod m for a runtime-loadable modulus m.
- Uses one restoring compare/subtract stage per quotient bit.
- Successor to the fixed-modulus reducer: generic widths, loadable modulus, valid/ready flow control with backpressure, and an optional quotient output.
- Sits between the wide-product datapath (multiplier output) and downstream field-arithmetic units.

Parameters:
- IN_W, 300, width of the input operand x.
- MOD_W, 256, width of the modulus and of the remainder; IN_W > MOD_W required.
- N (localparam), IN_W-MOD_W+1, number of pipeline stages, equal to the number of quotient bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mod_load  in  1  request to load a new modulus; held high until mod_ack.
- mod_in  in  MOD_W  modulus value to load.
- mod_ack  out  1  one-cycle pulse: load completed (accepted or rejected).
- mod_err  out  1  sticky; set when a load is rejected; cleared by the next accepted load.
- mod_valid  out  1  a legal modulus is held.
- in_valid  in  1  x is valid.
- in_ready  out  1  pipeline accepts x this cycle.
- x  in  IN_W  dividend.
- out_valid  out  1  out_rem is valid.
- out_ready  in  1  downstream accepts the result.
- out_rem  out  MOD_W  x mod m.
- out_quot  out  N  floor(x/m); present only with MOD_REDUCE_QUOT_EN.

Behaviour:
- Reset values:
  - mod_valid=0, mod_err=0, mod_ack=0, in_ready=0.
  - out_valid=0, out_rem=0, out_quot=0.
  - All stage valid bits and data registers 0; the modulus register is 0.
- Reset mid-operation: all in-flight data is discarded and a modulus reload is required.
- Legal modulus: mod_in[MOD_W-1]=1 (m >= 2^(MOD_W-1)). This guarantees x < m*2^N for all x, so the N stages fully reduce.
- Stage k (k=0..N-1), shift s=N-1-k:
  - If r >= (m<<s): r <= r-(m<<s) and quotient bit s <= 1.
  - Else: r passes unchanged and quotient bit s <= 0.
  - Stage 0 takes r=x. Stage k needs MOD_W+s+1 bits; the width narrows each stage.
- Flow control:
  - advance = !out_valid | out_ready. All stages shift together when advance=1 and hold when advance=0.
  - Bubbles are not squeezed out.
  - in_ready = advance & mod_valid & !mod_load.
  - A transfer occurs when in_valid & in_ready; otherwise a bubble (valid=0) enters stage 0.
- Latency: N cycles with no stall. x accepted at edge t gives out_valid=1 after edge t+N. Throughput is 1 per cycle.
- out_rem and out_quot are held stable while out_valid & !out_ready.
- Modulus load:
  - While mod_load=1, no new input is accepted; the pipeline continues to drain.
  - When all stage valid bits are 0 (out_valid included), the load completes:
    - Legal value: m <= mod_in, mod_valid <= 1, mod_err <= 0.
    - Illegal value (MSB clear): m unchanged, mod_valid unchanged, mod_err <= 1.
  - mod_ack pulses for exactly one cycle in either case.
  - mod_load asserted while the pipeline is already empty completes on the next edge.
  - The requester drops mod_load after mod_ack. If mod_load is still high the cycle after mod_ack, a second load is performed.
- Simultaneous mod_load and in_valid: the load has priority and in_ready=0.

Optional Feature:
- Macro MOD_REDUCE_QUOT_EN.
- Defined: each stage carries N quotient bits alongside the remainder, and port out_quot[N-1:0] = floor(x/m), aligned with out_rem and out_valid.
- Undefined: no quotient registers and no out_quot port; remainder behaviour is identical.

Test Plan (IN_W=8, MOD_W=4, N=5 unless noted):
- Reset, then mod_load with mod_in=13 → mod_ack pulse 1 cycle later, mod_valid=1, mod_err=0, in_ready=1.
- With m=13: x=200 → out_rem=5 and out_quot=15 exactly 5 cycles after acceptance. x=255 → out_rem=8, out_quot=19. x=12 → out_rem=12, out_quot=0.
- Back-to-back x=0..255 with out_ready=1 → one result per cycle, each out_rem = x%13, in order. Then hold out_ready=0 for 3 cycles mid-stream → outputs held stable, in_ready=0, no loss or duplication.
- mod_load with mod_in=6 (MSB clear) → mod_ack pulses, mod_err=1, m stays 13, subsequent x=100 → out_rem=9.
- Assert mod_load=15 with 3 items in flight → in_ready=0, the 3 results (old m) emerge first, then mod_ack; next x=100 → out_rem=10.
- Assert reset with 4 items in flight → next cycle out_valid=0, mod_valid=0, in_ready=0; no stale result ever appears.
